// File: rtl/conv_layer_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : conv_layer_sched
//  Purpose  : Frame sequencer for a three-layer convolution pipeline. Starts
//             the layer engines in order, arbitrates their requests onto one
//             shared result-memory port with per-layer select checking,
//             counts writes per layer and guards each layer with a watchdog.
//  Ports    : clk, rst_n (async, active-low)
//             i_ready            - host frame request
//             o_busy, o_stage    - frame in progress / current layer (0..3)
//             o_lN_start, i_lN_done - per-engine start / completion pulses
//             i_e_*              - request fields from the active engine
//             o_crd/o_cwr/o_csel/o_caddr_rd/o_caddr_wr/o_cdata_wr
//                                - registered shared memory port
//             o_err              - sticky {timeout, count mismatch, bad select}
//  Revision : 1.0 - initial release
// ============================================================================
module conv_layer_sched #(
  parameter int L0_WR   = 8192,
  parameter int L1_WR   = 2048,
  parameter int L2_WR   = 2048,
  parameter int TIMEOUT = 262143
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ready,
  output logic        o_busy,
  output logic [1:0]  o_stage,
  output logic        o_l0_start,
  output logic        o_l1_start,
  output logic        o_l2_start,
  input  logic        i_l0_done,
  input  logic        i_l1_done,
  input  logic        i_l2_done,
  input  logic        i_e_rd,
  input  logic        i_e_wr,
  input  logic [2:0]  i_e_sel,
  input  logic [11:0] i_e_raddr,
  input  logic [11:0] i_e_waddr,
  input  logic [19:0] i_e_wdata,
  output logic        o_crd,
  output logic        o_cwr,
  output logic [2:0]  o_csel,
  output logic [11:0] o_caddr_rd,
  output logic [11:0] o_caddr_wr,
  output logic [19:0] o_cdata_wr,
  output logic [2:0]  o_err
);

  localparam int c_WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_WDW-1:0] c_WD_LAST = c_WDW'(TIMEOUT - 1);
  localparam logic [13:0] c_WCNT_MAX = 14'h3FFF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L0   = 3'd1,
    S_L1   = 3'd2,
    S_L2   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t           r_state;
  logic [13:0]      r_wcnt;
  logic [c_WDW-1:0] r_wdog;

  logic        w_done;
  logic [13:0] w_need;
  logic        w_rd_ok;
  logic        w_wr_ok;
  logic        w_illegal;
  logic        w_timeout;

  // Per-layer select legality; outside the layer states nothing is forwarded
  always_comb begin
    w_done  = 1'b0;
    w_need  = 14'd0;
    w_rd_ok = 1'b0;
    w_wr_ok = 1'b0;
    case (r_state)
      S_L0: begin
        w_done  = i_l0_done;
        w_need  = 14'(L0_WR);
        w_wr_ok = i_e_wr && (i_e_sel == 3'd1 || i_e_sel == 3'd2);
      end
      S_L1: begin
        w_done  = i_l1_done;
        w_need  = 14'(L1_WR);
        w_rd_ok = i_e_rd && (i_e_sel == 3'd1 || i_e_sel == 3'd2);
        w_wr_ok = i_e_wr && (i_e_sel == 3'd3 || i_e_sel == 3'd4);
      end
      S_L2: begin
        w_done  = i_l2_done;
        w_need  = 14'(L2_WR);
        w_rd_ok = i_e_rd && (i_e_sel == 3'd3 || i_e_sel == 3'd4);
        w_wr_ok = i_e_wr && (i_e_sel == 3'd5);
      end
      default: ;
    endcase
  end

  assign w_illegal = (r_state == S_L0 || r_state == S_L1 || r_state == S_L2) &&
                     ((i_e_rd && !w_rd_ok) || (i_e_wr && !w_wr_ok));
  // r_wdog is 0 in the first cycle of a stage, so this flags cycle TIMEOUT
  assign w_timeout = (r_wdog == c_WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      o_busy     <= 1'b0;
      o_stage    <= 2'd0;
      o_l0_start <= 1'b0;
      o_l1_start <= 1'b0;
      o_l2_start <= 1'b0;
      o_crd      <= 1'b0;
      o_cwr      <= 1'b0;
      o_csel     <= 3'd0;
      o_caddr_rd <= 12'd0;
      o_caddr_wr <= 12'd0;
      o_cdata_wr <= 20'd0;
      o_err      <= 3'd0;
      r_wcnt     <= 14'd0;
      r_wdog     <= '0;
    end else begin
      o_l0_start <= 1'b0;
      o_l1_start <= 1'b0;
      o_l2_start <= 1'b0;

      // Memory port: legal requests registered, fields hold otherwise
      o_crd <= w_rd_ok;
      o_cwr <= w_wr_ok;
      if (w_rd_ok || w_wr_ok) o_csel <= i_e_sel;
      if (w_rd_ok) o_caddr_rd <= i_e_raddr;
      if (w_wr_ok) begin
        o_caddr_wr <= i_e_waddr;
        o_cdata_wr <= i_e_wdata;
      end
      if (w_illegal) o_err[0] <= 1'b1;
      if (w_wr_ok && r_wcnt != c_WCNT_MAX) r_wcnt <= r_wcnt + 14'd1;

      case (r_state)
        S_IDLE: begin
          if (i_ready) begin
            r_state    <= S_L0;
            o_busy     <= 1'b1;
            o_stage    <= 2'd1;
            o_l0_start <= 1'b1;
            o_err      <= 3'd0;
            r_wcnt     <= 14'd0;
            r_wdog     <= '0;
          end
        end
        S_L0, S_L1, S_L2: begin
          // done wins over a watchdog expiry in the same cycle
          if (w_done) begin
            if (r_wcnt != w_need) o_err[1] <= 1'b1;
            r_wcnt <= 14'd0;
            r_wdog <= '0;
            case (r_state)
              S_L0: begin
                r_state    <= S_L1;
                o_stage    <= 2'd2;
                o_l1_start <= 1'b1;
              end
              S_L1: begin
                r_state    <= S_L2;
                o_stage    <= 2'd3;
                o_l2_start <= 1'b1;
              end
              default: begin
                r_state <= S_FIN;
                o_busy  <= 1'b0;
              end
            endcase
          end else if (w_timeout) begin
            o_err[2] <= 1'b1;
            o_busy   <= 1'b0;
            o_stage  <= 2'd0;
            r_state  <= S_IDLE;
            r_wcnt   <= 14'd0;
            r_wdog   <= '0;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          o_stage <= 2'd0;
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
          o_stage <= 2'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_conv_layer_sched
//  Purpose  : Self-checking bench for conv_layer_sched. Random engine traffic
//             is driven cycle by cycle and every output is compared against a
//             frame-level behavioural model after each rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_layer_sched;

  localparam int P_L0 = 32;
  localparam int P_L1 = 16;
  localparam int P_L2 = 16;
  localparam int P_TO = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic        busy;
  logic [1:0]  stage;
  logic        l0_start, l1_start, l2_start;
  logic        l0_done, l1_done, l2_done;
  logic        e_rd, e_wr;
  logic [2:0]  e_sel;
  logic [11:0] e_raddr, e_waddr;
  logic [19:0] e_wdata;
  logic        crd, cwr;
  logic [2:0]  csel;
  logic [11:0] caddr_rd, caddr_wr;
  logic [19:0] cdata_wr;
  logic [2:0]  err;

  always #5 clk = ~clk;

  conv_layer_sched #(
    .L0_WR(P_L0), .L1_WR(P_L1), .L2_WR(P_L2), .TIMEOUT(P_TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_ready(ready),
    .o_busy(busy), .o_stage(stage),
    .o_l0_start(l0_start), .o_l1_start(l1_start), .o_l2_start(l2_start),
    .i_l0_done(l0_done), .i_l1_done(l1_done), .i_l2_done(l2_done),
    .i_e_rd(e_rd), .i_e_wr(e_wr), .i_e_sel(e_sel),
    .i_e_raddr(e_raddr), .i_e_waddr(e_waddr), .i_e_wdata(e_wdata),
    .o_crd(crd), .o_cwr(cwr), .o_csel(csel),
    .o_caddr_rd(caddr_rd), .o_caddr_wr(caddr_wr), .o_cdata_wr(cdata_wr),
    .o_err(err)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_l0s = 0, n_l1s = 0, n_l2s = 0;

  // ---------------- behavioural model ----------------
  // m_phase: 0 idle, 1..3 layer, 4 final cycle; m_cyc is the 1-based cycle
  // number within the current layer.
  int          m_phase, m_cyc, m_wcnt;
  logic        m_busy, m_crd, m_cwr;
  logic [2:0]  m_start, m_csel, m_err;
  logic [11:0] m_ard, m_awr;
  logic [19:0] m_dwr;
  int          need [4] = '{0, P_L0, P_L1, P_L2};

  function automatic bit rd_legal(int ph, logic [2:0] s);
    case (ph)
      2: return (s == 3'd1 || s == 3'd2);
      3: return (s == 3'd3 || s == 3'd4);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit wr_legal(int ph, logic [2:0] s);
    case (ph)
      1: return (s == 3'd1 || s == 3'd2);
      2: return (s == 3'd3 || s == 3'd4);
      3: return (s == 3'd5);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cyc = 0; m_wcnt = 0; m_busy = 0; m_crd = 0; m_cwr = 0;
    m_start = 0; m_csel = 0; m_err = 0; m_ard = 0; m_awr = 0; m_dwr = 0;
  endtask

  task automatic model_edge();
    bit rok, wok;
    int wbefore;
    logic [2:0] dn;
    if (!rst_n) begin model_reset(); return; end
    dn = {l2_done, l1_done, l0_done};
    wbefore = m_wcnt;
    m_start = 3'b000;
    rok = 0; wok = 0;
    if (m_phase >= 1 && m_phase <= 3) begin
      rok = e_rd && rd_legal(m_phase, e_sel);
      wok = e_wr && wr_legal(m_phase, e_sel);
      if ((e_rd && !rok) || (e_wr && !wok)) m_err[0] = 1'b1;
    end
    m_crd = rok; m_cwr = wok;
    if (rok || wok) m_csel = e_sel;
    if (rok) m_ard = e_raddr;
    if (wok) begin m_awr = e_waddr; m_dwr = e_wdata; end
    if (wok && m_wcnt < 16383) m_wcnt++;
    if (m_phase == 0) begin
      if (ready) begin
        m_phase = 1; m_busy = 1; m_start = 3'b001; m_err = 0; m_wcnt = 0; m_cyc = 1;
      end
    end else if (m_phase == 4) begin
      m_phase = 0;
    end else if (dn[m_phase-1]) begin
      if (wbefore != need[m_phase]) m_err[1] = 1'b1;
      m_phase++; m_wcnt = 0; m_cyc = 1;
      if (m_phase == 4) m_busy = 0;
      else m_start[m_phase-1] = 1'b1;
    end else if (m_cyc == P_TO) begin
      m_err[2] = 1'b1; m_busy = 0; m_phase = 0; m_wcnt = 0;
    end else begin
      m_cyc++;
    end
  endtask

  function automatic logic [1:0] m_stage();
    return (m_phase == 0) ? 2'd0 : (m_phase >= 3) ? 2'd3 : 2'(m_phase);
  endfunction

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("busy", busy, m_busy);
    chk("stage", stage, m_stage());
    chk("starts", {l2_start, l1_start, l0_start}, m_start);
    chk("crd", crd, m_crd);
    chk("cwr", cwr, m_cwr);
    chk("csel", csel, m_csel);
    chk("caddr_rd", caddr_rd, m_ard);
    chk("caddr_wr", caddr_wr, m_awr);
    chk("cdata_wr", cdata_wr, m_dwr);
    chk("err", err, m_err);
    if (l0_start === 1'b1) n_l0s++;
    if (l1_start === 1'b1) n_l1s++;
    if (l2_start === 1'b1) n_l2s++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    ready = 0; l0_done = 0; l1_done = 0; l2_done = 0;
    e_rd = 0; e_wr = 0; e_sel = 0; e_raddr = 0; e_waddr = 0; e_wdata = 0;
  endtask

  task automatic set_done(int ph);
    case (ph)
      1: l0_done = 1'b1;
      2: l1_done = 1'b1;
      default: l2_done = 1'b1;
    endcase
  endtask

  // Active engine issues nwr legal writes (plus legal reads), optionally with
  // done pulses from the wrong engines, then pulses its own done.
  task automatic run_stage(int ph, int nwr, bit noise);
    int w = 0;
    while (w < nwr) begin
      idle_inputs();
      if ($urandom_range(3) != 0) begin
        e_wr = 1;
        e_sel = (ph == 1) ? 3'(1 + $urandom_range(1)) :
                (ph == 2) ? 3'(3 + $urandom_range(1)) : 3'd5;
        e_waddr = 12'($urandom);
        e_wdata = 20'($urandom);
        w++;
      end else if (ph > 1 && $urandom_range(1) == 1) begin
        e_rd = 1;
        e_sel = (ph == 2) ? 3'(1 + $urandom_range(1)) : 3'(3 + $urandom_range(1));
        e_raddr = 12'($urandom);
      end
      if (noise && $urandom_range(7) == 0) set_done(((ph + $urandom_range(1)) % 3) + 1);
      tick();
    end
    idle_inputs(); tick();
    set_done(ph); tick();
    idle_inputs();
  endtask

  task automatic start_frame();
    idle_inputs(); ready = 1; tick(); ready = 0;
  endtask

  initial begin
    int guard;
    model_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    check_all();
    tick(); tick();
    rst_n = 1;
    tick();

    // Clean frame with wrong-engine done noise
    n_l0s = 0; n_l1s = 0; n_l2s = 0;
    start_frame();
    chk("accept_busy", busy, 1'b1);
    run_stage(1, P_L0, 1);
    run_stage(2, P_L1, 1);
    run_stage(3, P_L2, 1);
    chk("fin_busy", busy, 1'b0);
    chk("fin_stage", stage, 2'd3);
    ready = 1; tick(); ready = 0;          // ready in FIN is not taken
    chk("fin_ready_ignored", stage, 2'd0);
    tick();
    chk("clean_err", err, 3'b000);
    chk("l0_start_once", n_l0s, 1);
    chk("l1_start_once", n_l1s, 1);
    chk("l2_start_once", n_l2s, 1);

    // Layer 1 one write short
    start_frame();
    run_stage(1, P_L0, 0);
    run_stage(2, P_L1 - 1, 0);
    chk("short_err1", err, 3'b010);
    run_stage(3, P_L2, 0);
    tick();
    chk("short_done_idle", stage, 2'd0);
    chk("short_err_hold", err, 3'b010);

    // Illegal select then a legal write during layer 0
    start_frame();
    e_wr = 1; e_sel = 3'd5; e_waddr = 12'h111; e_wdata = 20'h22222; tick();
    chk("illegal_cwr", cwr, 1'b0);
    chk("illegal_err", err, 3'b001);
    e_sel = 3'd1; e_waddr = 12'hABC; e_wdata = 20'h12345; tick();
    idle_inputs();
    chk("legal_cwr", cwr, 1'b1);
    chk("legal_addr", caddr_wr, 12'hABC);
    chk("legal_data", cdata_wr, 20'h12345);
    run_stage(1, P_L0 - 1, 0);
    run_stage(2, P_L1, 0);
    run_stage(3, P_L2, 0);
    tick();
    chk("illegal_err_end", err, 3'b001);

    // Fully random traffic, including random ready and done pulses
    for (int i = 0; i < 600; i++) begin
      ready = ($urandom_range(3) == 0);
      l0_done = ($urandom_range(15) == 0);
      l1_done = ($urandom_range(15) == 0);
      l2_done = ($urandom_range(15) == 0);
      e_rd = $urandom_range(1); e_wr = $urandom_range(1);
      e_sel = 3'($urandom); e_raddr = 12'($urandom);
      e_waddr = 12'($urandom); e_wdata = 20'($urandom);
      tick();
    end
    idle_inputs();
    guard = 0;
    while (m_phase != 0 && guard < 300) begin tick(); guard++; end
    chk("drain_bounded", (guard < 300), 1'b1);
    tick();

    // Watchdog expiry in layer 0
    start_frame();
    repeat (P_TO - 1) tick();
    chk("wd_before_busy", busy, 1'b1);
    chk("wd_before_err", err, 3'b000);
    tick();
    chk("wd_err", err, 3'b100);
    chk("wd_busy", busy, 1'b0);
    chk("wd_stage", stage, 2'd0);
    tick();

    // done in the expiry cycle wins
    start_frame();
    repeat (P_TO - 1) tick();
    l0_done = 1; tick(); l0_done = 0;
    chk("wd_done_stage", stage, 2'd2);
    chk("wd_done_err2", err[2], 1'b0);
    chk("wd_done_l1start", l1_start, 1'b1);

    // Reset mid-layer-1 with a write on the port
    e_wr = 1; e_sel = 3'd3; e_waddr = 12'h5A5; e_wdata = 20'hFACE1; tick();
    chk("pre_reset_cwr", cwr, 1'b1);
    idle_inputs();
    rst_n = 0; #1;
    model_reset();
    check_all();
    chk("reset_cwr", cwr, 1'b0);
    tick(); rst_n = 1; tick();
    start_frame();
    chk("restart_stage", stage, 2'd1);
    chk("restart_l0start", l0_start, 1'b1);

    // Layer 2 done during layer 0 is ignored
    l2_done = 1; tick(); l2_done = 0;
    chk("stray_done_stage", stage, 2'd1);
    chk("stray_done_l1start", l1_start, 1'b0);
    run_stage(1, P_L0, 0);
    run_stage(2, P_L1, 0);
    run_stage(3, P_L2, 0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_layer_sched.md
CONV_LAYER_SCHED -- requirements
Module: conv_layer_sched

Interface
REQ-001 SHALL have parameter L0_WR, default 8192, required write count for layer 0 (two kernels x 4096).
REQ-002 SHALL have parameter L1_WR, default 2048, required write count for layer 1 (two kernels x 1024).
REQ-003 SHALL have parameter L2_WR, default 2048, required write count for layer 2 (flatten).
REQ-004 SHALL have parameter TIMEOUT, default 262143, maximum cycles per stage without a done pulse.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 ready  in  1  host request to start a frame.
REQ-008 busy  out  1  high from frame accept until frame end or abort.
REQ-009 stage  out  2  0 idle, 1 layer 0, 2 layer 1, 3 layer 2.
REQ-010 l0_start/l1_start/l2_start  out  1 each  one-cycle start pulse to the stage engine.
REQ-011 l0_done/l1_done/l2_done  in  1 each  one-cycle completion pulse from the stage engine.
REQ-012 e_rd, e_wr  in  1 each  engine read/write request; one engine drives these at a time.
REQ-013 e_sel  in  3; e_raddr, e_waddr  in  12 each; e_wdata  in  20  engine request fields.
REQ-014 crd, cwr  out  1; csel  out  3; caddr_rd, caddr_wr  out  12; cdata_wr  out  20  shared result-memory port.
REQ-015 err  out  3  sticky {timeout, count mismatch, illegal select}.

Function
REQ-016 FSM states SHALL be IDLE, L0, L1, L2, FIN; stage output SHALL equal 0,1,2,3 for IDLE,L0,L1,L2, and 3 in FIN.
REQ-017 In IDLE with ready=1 at a rising edge: next cycle busy=1, state L0, l0_start=1 for exactly one cycle, err cleared to 0, write counter and watchdog cleared.
REQ-018 Active-stage done pulse: write counter compared with LN_WR; mismatch sets err[1]; state advances L0->L1->L2->FIN; the next stage start pulse is issued in the cycle the new state is entered; counters cleared.
REQ-019 A done pulse from a non-active engine SHALL be ignored.
REQ-020 FIN SHALL last exactly one cycle with busy=0, then go to IDLE; ready high in FIN is not accepted until IDLE.
REQ-021 Watchdog SHALL count cycles in each stage; on reaching TIMEOUT with no done in that cycle: err[2]=1, busy=0, state IDLE next cycle; done in the same cycle SHALL take priority.
REQ-022 Legal select: L0 writes csel 1,2; L1 reads 1,2, writes 3,4; L2 reads 3,4, writes 5; every other select with e_rd or e_wr high sets err[0] and that request is suppressed (crd/cwr stay 0).
REQ-023 A legal request SHALL appear on the memory port registered, exactly one cycle after it is presented; crd, cwr SHALL be 0 in IDLE and FIN regardless of engine inputs.
REQ-024 When e_rd and e_wr are both high with the same legal select, both SHALL pass; csel SHALL take e_sel.
REQ-025 The write counter SHALL increment once per forwarded cwr, 14 bits, saturating at 16383.
REQ-026 err SHALL hold until the next frame accept or reset.

Reset
REQ-027 reset low SHALL immediately force state IDLE, busy=0, stage=0, all start pulses 0, crd=0, cwr=0, csel=0, addresses 0, cdata_wr=0, err=0, counters 0, including mid-frame.
REQ-028 After reset release, the first ready sampled high in IDLE SHALL start a frame normally.

Verification
REQ-029 ready=1 one cycle, engines write exactly 8192/2048/2048 then pulse done -> busy high throughout, l0/l1/l2_start each once, busy low in FIN, err=000.
REQ-030 L1 engine writes 2047 words then l1_done -> err[1]=1, sequence still completes through L2 and FIN.
REQ-031 During L0, e_wr=1 with e_sel=5 -> cwr stays 0, err[0]=1; legal e_sel=1 write to address 12'hABC, data 20'h12345 -> cwr=1, caddr_wr=12'hABC, cdata_wr=20'h12345 one cycle later.
REQ-032 TIMEOUT=100, no l0_done -> err[2]=1 and busy=0 in the cycle after cycle 100 of L0; l0_done arriving at cycle 100 -> advance to L1, err[2]=0.
REQ-033 reset asserted mid-L1 with cwr active -> all outputs zero immediately; new ready after release -> frame restarts at L0.
REQ-034 l2_done pulsed during L0 -> ignored, state stays L0, no l1_start.
